// File: rtl/axis_spi_slave.sv
// SPI slave (CPOL=0, CPHA=1, LSB first, 8-bit words) bridged to AXI-Stream.
//
// The SPI pins are oversampled on aclk. SCK, SS_N and MOSI each pass a
// SYNC_STAGES flop synchroniser, and edges are found against a one-cycle-delayed copy.
//
// Parameters
//   SYNC_STAGES  synchroniser depth (2..4). Each SCK phase must last at least
//                SYNC_STAGES+2 aclk cycles.
//   IDLE_BYTE    byte shifted out when no TX byte is cached.
//
// Ports
//   aclk, aresetn              clock, asynchronous active-low reset
//   SCK, SS_N, MOSI            SPI inputs from the master
//   MISO_Z                     SPI output, high-Z while deselected
//   s_axis_tdata/tvalid/tready TX bytes into a one-entry cache
//   m_axis_tdata/tvalid/tready RX bytes out of a one-entry holding register
//   stat_rx_overflow           pulse: a completed RX byte was dropped
//   stat_tx_underflow          pulse: IDLE_BYTE substituted for a TX byte
module axis_spi_slave #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  IDLE_BYTE   = 8'h00
) (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic       SCK,
  input  logic       SS_N,
  input  logic       MOSI,
  output logic       MISO_Z,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       stat_rx_overflow,
  output logic       stat_tx_underflow
);

  typedef enum logic [1:0] {StIdle, StLoad, StShift} state_e;

  // Synchronisers and edge detection
  logic [SYNC_STAGES-1:0] sck_sync_q, ss_sync_q, mosi_sync_q;
  logic sck_dly_q, ss_dly_q;
  logic sck_s, ss_s, mosi_s;
  logic sck_rise, sck_fall, ss_fall;

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign ss_s     = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_dly_q;
  assign sck_fall = ~sck_s & sck_dly_q;
  assign ss_fall  = ~ss_s & ss_dly_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sck_sync_q  <= '0;
      ss_sync_q   <= '1;
      mosi_sync_q <= '0;
      sck_dly_q   <= 1'b0;
      ss_dly_q    <= 1'b1;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], SCK};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], SS_N};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
      sck_dly_q   <= sck_s;
      ss_dly_q    <= ss_s;
    end
  end

  // Datapath state
  state_e     st_q, st_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic       rx_done_q, rx_done_d;
  logic [7:0] rx_byte_q, rx_byte_d;
  logic       miso_q, miso_d;
  logic       miso_en_q, miso_en_d;
  logic       unf_pend_q, unf_pend_d;
  logic       unf_q, unf_d;
  logic       ovf_q, ovf_d;
  logic [7:0] tx_cache_q, tx_cache_d;
  logic       tx_cache_v_q, tx_cache_v_d;
  logic       s_tready_q, s_tready_d;
  logic [7:0] m_tdata_q, m_tdata_d;
  logic       m_tvalid_q, m_tvalid_d;
  logic       boundary, load, cache_hs;

  assign boundary = (st_q == StShift) && !ss_s && sck_fall && (bit_cnt_q == 3'd7);
  assign load     = (st_q == StLoad) || boundary;
  assign cache_hs = s_axis_tvalid && s_tready_q;

  always_comb begin
    st_d         = st_q;
    bit_cnt_d    = bit_cnt_q;
    tx_shift_d   = tx_shift_q;
    rx_shift_d   = rx_shift_q;
    rx_done_d    = 1'b0;
    rx_byte_d    = rx_byte_q;
    miso_d       = miso_q;
    miso_en_d    = miso_en_q;
    unf_pend_d   = unf_pend_q;
    unf_d        = 1'b0;
    ovf_d        = 1'b0;
    tx_cache_d   = tx_cache_q;
    tx_cache_v_d = tx_cache_v_q;
    m_tdata_d    = m_tdata_q;
    m_tvalid_d   = m_tvalid_q;

    unique case (st_q)
      StIdle: begin
        miso_en_d  = 1'b0;
        bit_cnt_d  = 3'd0;
        unf_pend_d = 1'b0;
        if (ss_fall) begin
          st_d      = StLoad;
          miso_en_d = 1'b1;
          miso_d    = 1'b0;
        end
      end
      StLoad: begin
        st_d      = StShift;
        miso_en_d = 1'b1;
        miso_d    = 1'b0;
        bit_cnt_d = 3'd0;
      end
      StShift: begin
        if (ss_s) begin
          // Deselect: abandon partial RX bits and the loaded TX byte.
          st_d       = StIdle;
          miso_en_d  = 1'b0;
          bit_cnt_d  = 3'd0;
          unf_pend_d = 1'b0;
        end else begin
          if (sck_rise) begin
            miso_d = tx_shift_q[bit_cnt_q];
            if ((bit_cnt_q == 3'd0) && unf_pend_q) begin
              unf_d      = 1'b1;
              unf_pend_d = 1'b0;
            end
          end
          if (sck_fall) begin
            rx_shift_d[bit_cnt_q] = mosi_s;
            bit_cnt_d             = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              rx_done_d = 1'b1;
              rx_byte_d = rx_shift_d;
            end
          end
        end
      end
      default: st_d = StIdle;
    endcase

    // TX load. A substitution at a byte boundary is only reported once that
    // byte actually starts shifting, so a transfer ending cleanly on a byte
    // boundary does not flag a byte that is never sent.
    if (load) begin
      if (tx_cache_v_q) begin
        tx_shift_d   = tx_cache_q;
        tx_cache_v_d = 1'b0;
        unf_pend_d   = 1'b0;
      end else begin
        tx_shift_d = IDLE_BYTE;
        if (st_q == StLoad) begin
          unf_d = 1'b1;
        end else begin
          unf_pend_d = 1'b1;
        end
      end
    end

    // A write landing with a load refills the cache after the old entry left.
    if (cache_hs) begin
      tx_cache_d   = s_axis_tdata;
      tx_cache_v_d = 1'b1;
    end

    // RX holding register
    if (m_tvalid_q && m_axis_tready) begin
      m_tvalid_d = 1'b0;
    end
    if (rx_done_q) begin
      if (!m_tvalid_q || m_axis_tready) begin
        m_tdata_d  = rx_byte_q;
        m_tvalid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  assign s_tready_d = !tx_cache_v_d;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      st_q         <= StIdle;
      bit_cnt_q    <= 3'd0;
      tx_shift_q   <= 8'h00;
      rx_shift_q   <= 8'h00;
      rx_done_q    <= 1'b0;
      rx_byte_q    <= 8'h00;
      miso_q       <= 1'b0;
      miso_en_q    <= 1'b0;
      unf_pend_q   <= 1'b0;
      unf_q        <= 1'b0;
      ovf_q        <= 1'b0;
      tx_cache_q   <= 8'h00;
      tx_cache_v_q <= 1'b0;
      s_tready_q   <= 1'b0;
      m_tdata_q    <= 8'h00;
      m_tvalid_q   <= 1'b0;
    end else begin
      st_q         <= st_d;
      bit_cnt_q    <= bit_cnt_d;
      tx_shift_q   <= tx_shift_d;
      rx_shift_q   <= rx_shift_d;
      rx_done_q    <= rx_done_d;
      rx_byte_q    <= rx_byte_d;
      miso_q       <= miso_d;
      miso_en_q    <= miso_en_d;
      unf_pend_q   <= unf_pend_d;
      unf_q        <= unf_d;
      ovf_q        <= ovf_d;
      tx_cache_q   <= tx_cache_d;
      tx_cache_v_q <= tx_cache_v_d;
      s_tready_q   <= s_tready_d;
      m_tdata_q    <= m_tdata_d;
      m_tvalid_q   <= m_tvalid_d;
    end
  end

  assign MISO_Z            = miso_en_q ? miso_q : 1'bz;
  assign s_axis_tready     = s_tready_q;
  assign m_axis_tdata      = m_tdata_q;
  assign m_axis_tvalid     = m_tvalid_q;
  assign stat_rx_overflow  = ovf_q;
  assign stat_tx_underflow = unf_q;

endmodule
